fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Front end of the F stage: owns the program counter and drives the instruction cache's word address.
- Captures the combinational instruction response, together with its PC, into a small instruction queue.
- Presents queue entries to the D stage over a valid/ready handshake.
- Handles PC redirects from later stages (taken branches, jumps) by flushing the queue and restarting fetch at the target.

Parameters:
- DEPTH, 4, queue entries; must be a power of two, 2..16.
- RESET_PC, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low: 0 asserts immediately, release is synchronous to clock.
- ic_addr  out  32  icache word index = {2'b00, pc[31:2]}.
- ic_instr  in  32  icache data for ic_addr, valid in the same cycle (combinational cache).
- redirect_valid  in  1  redirect request from EX.
- redirect_pc  in  32  redirect target byte address; bits [1:0] are ignored (forced to 0).
- dec_valid  out  1  head entry is valid.
- dec_ready  in  1  D stage accepts the head entry this cycle.
- dec_instr  out  32  head entry instruction.
- dec_pc  out  32  head entry byte PC.
- fq_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC; read/write pointers=0; count=0.
  - All queue entries cleared to 0, so dec_instr=0, dec_pc=0, dec_valid=0, fq_count=0.
  - ic_addr=RESET_PC>>2.
- Derived signals:
  - deq = dec_valid & dec_ready.
  - dec_valid = (count!=0), taken from registered state only; it never depends on dec_ready.
  - dec_instr and dec_pc are read directly from the head entry's storage.
- Fetch enable: fetch = !redirect_valid & ((count<DEPTH) | deq). A full queue may enqueue in the same cycle it dequeues.
- When fetch=1 at a rising edge:
  - Write {ic_instr, pc} to the tail entry and increment the write pointer.
  - pc <= pc+4, wrapping mod 2^32 (32'hFFFFFFFC -> 0).
- When fetch=0 and there is no redirect: pc holds and ic_addr stays stable.
- Occupancy update: count' = count + fetch - deq. Pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1 at a rising edge), which has priority over everything else:
  - pc <= {redirect_pc[31:2], 2'b00}; both pointers reset to 0; count <= 0.
  - No enqueue that cycle. A simultaneous deq is still a legal handshake from D's point of view, but the entry is discarded along with the rest.
- Redirect latency:
  - Redirect sampled at edge N; the target is fetched during cycle N and enqueued at edge N+1.
  - dec_valid is 0 for cycle N..N+1 and 1 from edge N+1 onward: one bubble.
- Throughput: 1 instruction/cycle steady state while D is always ready.
- Back-pressure:
  - With dec_ready=0, the queue fills after DEPTH cycles.
  - After that, pc and ic_addr freeze and dec_instr/dec_pc hold stable.
- Reset asserted mid-operation: all state returns to reset values immediately. No partial entry survives.
- Queue storage holds only data; valid-ness is derived from count alone.
- Back-to-back redirects on consecutive edges: the last one wins, and dec_valid stays 0 until one cycle after the final redirect.

Decomposition:
- Shared header core_defines.vh:
  - XLEN=32.
  - RESET_PC default.
  - INSTR_NOP=32'h00000013.
  - Width of the PC-increment constant (4).
- One natural sub-module: fetch_queue.
  - Synchronous FIFO of {instr, pc} entries, DEPTH deep.
  - Ports: push, pop, flush, count.
  - Reset is asynchronous and active-low.
- fetch_unit itself contains only the pc register, the next-PC mux, and the fetch-enable logic.

Test Plan:
- Reset release, RESET_PC=0, dec_ready=1, cache returns 32'h100+index:
  - ic_addr steps 0,1,2,3...
  - dec_valid rises after the first edge.
  - dec_pc = 0,4,8,12 on consecutive cycles with matching dec_instr.
- dec_ready=0 from reset:
  - fq_count reaches DEPTH after 4 edges, then ic_addr freezes at 4.
  - Raising dec_ready then drains one per cycle while fetch resumes at pc 16, so fq_count stays 4.
- Redirect to 32'h00000042 while the queue holds 3 entries:
  - Next cycle: fq_count=0, dec_valid=0, ic_addr=32'h10.
  - One cycle later: dec_valid=1 with dec_pc=32'h40.
- Redirect with simultaneous dec_ready=1 and a full queue:
  - No enqueue that cycle and queue empty afterwards.
  - The first post-redirect dec_pc equals the target.
- PC wrap: RESET_PC=32'hFFFFFFF8, dec_ready=1 -> dec_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- Assert reset mid-stream with the queue at 2 entries:
  - dec_valid=0 and fq_count=0 immediately, without waiting for a clock edge.
  - ic_addr=RESET_PC>>2.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN             : architectural word width
//   RESET_PC_DEFAULT : default PC loaded on reset
//   INSTR_NOP        : canonical NOP encoding (addi x0, x0, 0)
//   PC_INC           : per-instruction PC increment (4 bytes)
//   fq_entry_t       : one instruction-queue entry {instr, pc}
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam int PC_INC_W = 3;
  localparam logic [PC_INC_W-1:0] PC_INC = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  // Clear the byte-offset bits of a byte address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between the F and D stages.
// Synchronous FIFO of {instr, pc} entries, DEPTH deep (power of two).
// Ports:
//   clock      : core clock
//   reset      : asynchronous active-low reset (clears storage, pointers, count)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : retire the head entry (caller guarantees count != 0)
//   flush      : discard all entries; overrides push and pop
//   head_data  : head entry, read straight from storage
//   count      : current occupancy, 0..DEPTH
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fq_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fq_entry_t                  head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero before the first
  // fetch. When full, push and pop hit the same slot: the old head is
  // consumed at the same edge it is overwritten.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// F-stage front end: owns the PC, drives the icache word address, captures
// the combinational icache response into the instruction queue and presents
// the head entry to D over a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the target.
// Ports:
//   clock, reset        : core clock, asynchronous active-low reset
//   ic_addr / ic_instr  : icache word index out, same-cycle instruction in
//   redirect_valid/_pc  : redirect request and byte target from EX
//   dec_valid/_ready    : handshake with D
//   dec_instr / dec_pc  : head entry contents
//   fq_count            : queue occupancy
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [XLEN-1:0]        ic_addr,
  input  logic [XLEN-1:0]        ic_instr,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [XLEN-1:0]        dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            deq;
  logic            fetch;
  logic            full;
  fq_entry_t       head;
  fq_entry_t       push_data;
  logic            unused_redirect_lsbs;

  // Target byte-offset bits are dropped by word_align.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Validity comes from registered occupancy only, never from dec_ready.
  assign dec_valid = (fq_count != '0);
  assign deq       = dec_valid & dec_ready;
  assign full      = (fq_count == CNT_W'(DEPTH));
  // A full queue can still accept when the head leaves in the same cycle.
  assign fetch     = !redirect_valid & (!full | deq);

  assign push_data = '{instr: ic_instr, pc: pc_q};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else if (fetch) begin
      pc_d = pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign ic_addr = {2'b00, pc_q[XLEN-1:2]};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (fetch),
    .push_data (push_data),
    .pop       (deq),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (fq_count)
  );

  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;

endmodule
